// File: rtl/axi_rx_arbiter.sv
// Round-robin burst scheduler: shares one AXI-Stream master among NUM_LANES receive lanes.
// Define AXI_RX_ARB_TUSER_EN to add m_tuser carrying the source lane of each output word.
module axi_rx_arbiter #(
   parameter  int NUM_LANES    = 4,
   parameter  int DATA_WIDTH   = 32,
   parameter  int BURST_LEN    = 4,
   parameter  int IDLE_TIMEOUT = 64,
   localparam int GW           = $clog2(NUM_LANES)
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] s_tdata,
   input  logic [NUM_LANES-1:0]            s_tvalid,
   output logic [NUM_LANES-1:0]            s_tready,
   output logic [DATA_WIDTH-1:0]           m_tdata,
   output logic                            m_tvalid,
   output logic                            m_tlast,
   input  logic                            m_tready,
`ifdef AXI_RX_ARB_TUSER_EN
   output logic [GW-1:0]                   m_tuser,
`endif
   output logic [GW-1:0]                   grant,
   output logic                            busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_CLOSE = 2'd2
   } state_t;

   localparam logic [7:0]    BURST_LAST = 8'(BURST_LEN);
   localparam logic [7:0]    TIMER_LAST = 8'(IDLE_TIMEOUT - 1);
   localparam logic [GW-1:0] LANE_MAX   = GW'(NUM_LANES - 1);

   state_t                state_q, state_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [7:0]            timer_q, timer_d;
   logic [DATA_WIDTH-1:0] h_data_q, h_data_d;
   logic                  h_valid_q, h_valid_d;
   logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
   logic                  o_valid_q, o_valid_d;
   logic                  o_last_q, o_last_d;
`ifdef AXI_RX_ARB_TUSER_EN
   logic [GW-1:0]         o_user_q, o_user_d;
`endif

   logic                  o_free;
   logic                  lane_rdy;
   logic                  beat;
   logic                  pick_found;
   logic [GW-1:0]         pick_lane;
   logic [GW-1:0]         grant_next;
   logic [DATA_WIDTH-1:0] lane_data;

   assign o_free     = !o_valid_q || m_tready;
   assign lane_rdy   = !h_valid_q || o_free;
   assign lane_data  = s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
   assign grant_next = (grant_q == LANE_MAX) ? '0 : grant_q + GW'(1);

   // First requester at or after rr_ptr, wrapping around the lane set.
   always_comb begin
      int            idx;
      logic [GW-1:0] idx_l;
      idx        = 0;
      idx_l      = '0;
      pick_found = 1'b0;
      pick_lane  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_LANES) idx = idx - NUM_LANES;
         idx_l = GW'(idx);
         if (!pick_found && s_tvalid[idx_l]) begin
            pick_found = 1'b1;
            pick_lane  = idx_l;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      timer_d   = timer_q;
      h_data_d  = h_data_q;
      h_valid_d = h_valid_q;
      o_data_d  = o_data_q;
      o_valid_d = o_valid_q;
      o_last_d  = o_last_q;
`ifdef AXI_RX_ARB_TUSER_EN
      o_user_d  = o_user_q;
`endif
      s_tready  = '0;
      beat      = 1'b0;

      // Drain; any reload below in the same cycle overrides it.
      if (m_tready) begin
         o_valid_d = 1'b0;
         o_last_d  = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d = ST_BURST;
               grant_d = pick_lane;
               cnt_d   = '0;
               timer_d = '0;
            end
         end
         ST_BURST: begin
            s_tready[grant_q] = lane_rdy;
            beat              = s_tvalid[grant_q] && lane_rdy;
            if (beat) begin
               if (h_valid_q) begin
                  o_data_d  = h_data_q;
                  o_valid_d = 1'b1;
                  o_last_d  = 1'b0;
`ifdef AXI_RX_ARB_TUSER_EN
                  o_user_d  = grant_q;
`endif
               end
               h_data_d  = lane_data;
               h_valid_d = 1'b1;
               cnt_d     = cnt_q + 8'd1;
               timer_d   = '0;
               if (cnt_q + 8'd1 == BURST_LAST) begin
                  state_d  = ST_CLOSE;
                  rr_ptr_d = grant_next;
                  cnt_d    = '0;
               end
            end else if (timer_q == TIMER_LAST) begin
               // Idle lane: close a held partial burst, or just release the grant.
               state_d  = h_valid_q ? ST_CLOSE : ST_IDLE;
               rr_ptr_d = grant_next;
               cnt_d    = '0;
               timer_d  = '0;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         ST_CLOSE: begin
            if (o_free) begin
               o_data_d  = h_data_q;
               o_valid_d = 1'b1;
               o_last_d  = 1'b1;
`ifdef AXI_RX_ARB_TUSER_EN
               o_user_d  = grant_q;
`endif
               h_valid_d = 1'b0;
               state_d   = ST_IDLE;
               rr_ptr_d  = grant_next;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         cnt_q     <= '0;
         timer_q   <= '0;
         h_data_q  <= '0;
         h_valid_q <= 1'b0;
         o_data_q  <= '0;
         o_valid_q <= 1'b0;
         o_last_q  <= 1'b0;
`ifdef AXI_RX_ARB_TUSER_EN
         o_user_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         cnt_q     <= cnt_d;
         timer_q   <= timer_d;
         h_data_q  <= h_data_d;
         h_valid_q <= h_valid_d;
         o_data_q  <= o_data_d;
         o_valid_q <= o_valid_d;
         o_last_q  <= o_last_d;
`ifdef AXI_RX_ARB_TUSER_EN
         o_user_q  <= o_user_d;
`endif
      end
   end

   assign m_tdata  = o_data_q;
   assign m_tvalid = o_valid_q;
   assign m_tlast  = o_last_q;
`ifdef AXI_RX_ARB_TUSER_EN
   assign m_tuser  = o_user_q;
`endif
   assign grant    = grant_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi_rx_arbiter.sv
// Bench for axi_rx_arbiter: cycle vector table, directed burst scenarios and a randomized
// scoreboard run; m_tuser is checked when AXI_RX_ARB_TUSER_EN is defined.
module tb_axi_rx_arbiter;
   localparam int NL = 4;
   localparam int DW = 32;
   localparam int BL = 4;
   localparam int TO = 64;

   logic             aclk = 1'b0;
   logic             areset;
   logic [NL*DW-1:0] s_tdata;
   logic [NL-1:0]    s_tvalid;
   logic [NL-1:0]    s_tready;
   logic [DW-1:0]    m_tdata;
   logic             m_tvalid;
   logic             m_tlast;
   logic             m_tready;
   logic [1:0]       grant;
   logic             busy;
`ifdef AXI_RX_ARB_TUSER_EN
   logic [1:0]       m_tuser;
`endif

   axi_rx_arbiter #(.NUM_LANES(NL), .DATA_WIDTH(DW), .BURST_LEN(BL), .IDLE_TIMEOUT(TO)) dut (
      .aclk     (aclk),
      .areset   (areset),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tlast  (m_tlast),
      .m_tready (m_tready),
`ifdef AXI_RX_ARB_TUSER_EN
      .m_tuser  (m_tuser),
`endif
      .grant    (grant),
      .busy     (busy)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [3:0]  vld;
      logic        rdy;
      logic [31:0] dat;
      logic [3:0]  e_srdy;
      logic        e_mv;
      logic [31:0] e_md;
      logic        e_ml;
      logic [1:0]  e_gnt;
      logic        e_busy;
   } vec_t;

   int n_chk  = 0;
   int n_fail = 0;

   // Scoreboard: each lane emits words {D, lane, seq}; output must return them in order.
   int         target[NL], remaining[NL], sent_seq[NL], acc_cnt[NL], out_cnt[NL];
   logic [NL-1:0] vld_r, hs;
   bit         rand_valid, rand_ready;
   int         vpct, rpct;
   logic       rdy_level;
   int         cyc;
   int         cur_lane, cur_len;
   int         burst_lane[$], burst_len[$], emit_cyc[$];
   bit         emit_last[$], emit_busy[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int lane, input int seq);
      return {4'hD, 4'(lane), 24'(seq)};
   endfunction

   task automatic clear_sb();
      for (int i = 0; i < NL; i++) begin
         target[i] = 0; remaining[i] = 0; sent_seq[i] = 0; acc_cnt[i] = 0; out_cnt[i] = 0;
      end
      vld_r = '0; hs = '0;
      rand_valid = 0; rand_ready = 0; vpct = 100; rpct = 100; rdy_level = 1'b1;
      cyc = 0; cur_lane = -1; cur_len = 0;
      burst_lane.delete(); burst_len.delete(); emit_cyc.delete();
      emit_last.delete(); emit_busy.delete();
   endtask

   task automatic load_targets();
      for (int i = 0; i < NL; i++) remaining[i] = target[i];
   endtask

   task automatic drive();
      for (int i = 0; i < NL; i++) begin
         if (hs[i]) begin
            sent_seq[i]++;
            remaining[i]--;
            vld_r[i] = 1'b0;
         end
         if (remaining[i] > 0) begin
            if (!vld_r[i]) vld_r[i] = rand_valid ? ($urandom_range(0, 99) < vpct) : 1'b1;
         end else begin
            vld_r[i] = 1'b0;
         end
         s_tdata[i*DW +: DW] = mk(i, sent_seq[i]);
      end
      hs       = '0;
      s_tvalid = vld_r;
      m_tready = rand_ready ? ($urandom_range(0, 99) < rpct) : rdy_level;
   endtask

   task automatic monitor();
      logic [NL-1:0] e;
      int ln, sq;
      cyc++;
      chk("s_tready_onehot0", $onehot0(s_tready), 1);
      if (s_tready != '0) begin
         e = '0;
         e[grant] = 1'b1;
         chk("s_tready_is_grant", s_tready, e);
      end
      for (int i = 0; i < NL; i++) begin
         hs[i] = s_tvalid[i] && s_tready[i];
         if (hs[i]) acc_cnt[i]++;
      end
      if (m_tvalid && m_tready) begin
         ln = 32'(m_tdata[27:24]);
         sq = 32'(m_tdata[23:0]);
         chk("out_lane_range", ln < NL, 1);
         if (ln < NL) begin
            chk("out_seq", sq, out_cnt[ln]);
            out_cnt[ln]++;
         end
         if (cur_len > 0) chk("no_interleave", ln, cur_lane);
         cur_lane = ln;
         cur_len++;
         chk("burst_len_max", cur_len <= BL, 1);
         if (cur_len == BL) chk("tlast_at_full", m_tlast, 1);
`ifdef AXI_RX_ARB_TUSER_EN
         chk("tuser", m_tuser, ln);
`endif
         emit_cyc.push_back(cyc);
         emit_last.push_back(m_tlast);
         emit_busy.push_back(busy);
         if (m_tlast) begin
            burst_lane.push_back(cur_lane);
            burst_len.push_back(cur_len);
            cur_len = 0;
         end
      end
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(negedge aclk);
         monitor();
         @(posedge aclk);
         #1;
         drive();
      end
   endtask

   function automatic bit all_done();
      bit d;
      d = !busy && !m_tvalid;
      for (int i = 0; i < NL; i++) if (out_cnt[i] != target[i]) d = 0;
      return d;
   endfunction

   task automatic wait_done(input string name, input int cap);
      int k;
      bit done;
      k = 0;
      done = 0;
      while (!done && k < cap) begin
         run_cycles(1);
         k++;
         done = all_done();
      end
      chk({name, "_done"}, done, 1);
   endtask

   task automatic do_reset();
      areset   = 1'b1;
      s_tvalid = '0;
      s_tdata  = '0;
      m_tready = 1'b0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      areset = 1'b0;
   endtask

   task automatic chk_bursts(input string name, input int n, input int l0, input int l1);
      chk({name, "_nbursts"}, burst_lane.size(), n);
      for (int k = 0; k < burst_lane.size() && k < n; k++) begin
         chk({name, "_lane"}, burst_lane[k], (k % 2 == 0) ? l0 : l1);
         chk({name, "_len"}, burst_len[k], BL);
      end
   endtask

   initial begin
      vec_t tbl[7];
      int   k, nl;

      tbl[0] = '{4'b0100, 1'b1, 32'hA0, 4'b0100, 1'b0, 32'h0,  1'b0, 2'd2, 1'b1};
      tbl[1] = '{4'b0100, 1'b1, 32'hA0, 4'b0100, 1'b0, 32'h0,  1'b0, 2'd2, 1'b1};
      tbl[2] = '{4'b0100, 1'b1, 32'hA1, 4'b0100, 1'b1, 32'hA0, 1'b0, 2'd2, 1'b1};
      tbl[3] = '{4'b0100, 1'b1, 32'hA2, 4'b0100, 1'b1, 32'hA1, 1'b0, 2'd2, 1'b1};
      tbl[4] = '{4'b0100, 1'b1, 32'hA3, 4'b0000, 1'b1, 32'hA2, 1'b0, 2'd2, 1'b1};
      tbl[5] = '{4'b0000, 1'b1, 32'h0,  4'b0000, 1'b1, 32'hA3, 1'b1, 2'd2, 1'b0};
      tbl[6] = '{4'b0000, 1'b1, 32'h0,  4'b0000, 1'b0, 32'h0,  1'b0, 2'd2, 1'b0};

      clear_sb();
      areset   = 1'b0;
      s_tvalid = '0;
      s_tdata  = '0;
      m_tready = 1'b0;
      #1 areset = 1'b1;
      #2;
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      areset = 1'b0;

      // Lane 2 alone, four words, cycle-exact vectors.
      for (int v = 0; v < 7; v++) begin
         s_tvalid = tbl[v].vld;
         m_tready = tbl[v].rdy;
         s_tdata  = '0;
         s_tdata[2*DW +: DW] = tbl[v].dat;
         @(posedge aclk);
         #1;
         chk($sformatf("tbl%0d_s_tready", v), s_tready, tbl[v].e_srdy);
         chk($sformatf("tbl%0d_m_tvalid", v), m_tvalid, tbl[v].e_mv);
         if (tbl[v].e_mv) begin
            chk($sformatf("tbl%0d_m_tdata", v), m_tdata, tbl[v].e_md);
            chk($sformatf("tbl%0d_m_tlast", v), m_tlast, tbl[v].e_ml);
         end
         chk($sformatf("tbl%0d_grant", v), grant, tbl[v].e_gnt);
         chk($sformatf("tbl%0d_busy", v), busy, tbl[v].e_busy);
      end

      // Lanes 0 and 1 both requesting: bursts must alternate 0,1,0,...
      do_reset(); clear_sb();
      target[0] = 12; target[1] = 12;
      load_targets(); drive();
      wait_done("alt", 400);
      chk_bursts("alt", 6, 0, 1);

      // Lanes 1 and 3 alternating.
      do_reset(); clear_sb();
      target[1] = 8; target[3] = 8;
      load_targets(); drive();
      wait_done("alt13", 300);
      chk_bursts("alt13", 4, 1, 3);

      // Lane 3 sends two words then stops: second word closed by the idle timeout.
      do_reset(); clear_sb();
      target[3] = 2;
      load_targets(); drive();
      wait_done("tmo", 300);
      chk("tmo_nwords", emit_cyc.size(), 2);
      if (emit_cyc.size() == 2) begin
         chk("tmo_last0", emit_last[0], 0);
         chk("tmo_last1", emit_last[1], 1);
         chk("tmo_gap", emit_cyc[1] - emit_cyc[0], TO + 1);
         chk("tmo_busy0", emit_busy[0], 1);
         chk("tmo_busy1", emit_busy[1], 0);
      end
      chk("tmo_grant", grant, 3);

      // Back-pressure: m_tready low while lane 1 streams four words.
      do_reset(); clear_sb();
      target[1] = 4;
      rdy_level = 1'b0;
      load_targets(); drive();
      run_cycles(20);
      chk("bp_s_tready", s_tready, 0);
      chk("bp_accepted", acc_cnt[1], 2);
      chk("bp_emitted", out_cnt[1], 0);
      chk("bp_m_tvalid", m_tvalid, 1);
      chk("bp_m_tdata", m_tdata, mk(1, 0));
      rdy_level = 1'b1;
      wait_done("bp", 100);
      chk("bp_nbursts", burst_lane.size(), 1);
      if (burst_lane.size() == 1) begin
         chk("bp_lane", burst_lane[0], 1);
         chk("bp_len", burst_len[0], 4);
      end
      nl = 0;
      foreach (emit_last[j]) if (emit_last[j]) nl++;
      chk("bp_single_tlast", nl, 1);

      // Asynchronous reset while lane 2's third word is on the bus.
      do_reset(); clear_sb();
      target[2] = 4;
      load_targets(); drive();
      k = 0;
      while (acc_cnt[2] < 2 && k < 50) begin
         run_cycles(1);
         k++;
      end
      chk("mid_reached", acc_cnt[2], 2);
      chk("mid_m_tvalid", m_tvalid, 1);
      chk("mid_busy", busy, 1);
      #2 areset = 1'b1;
      #1;
      chk("arst_s_tready", s_tready, 0);
      chk("arst_m_tvalid", m_tvalid, 0);
      chk("arst_m_tlast", m_tlast, 0);
      chk("arst_m_tdata", m_tdata, 0);
      chk("arst_grant", grant, 0);
      chk("arst_busy", busy, 0);
      @(posedge aclk);
      @(negedge aclk);
      areset = 1'b0;
      clear_sb();
      target[0] = 4; target[2] = 4;
      load_targets(); drive();
      wait_done("post_rst", 200);
      chk_bursts("post_rst", 2, 0, 2);

      // Randomized valid/ready on all lanes against the scoreboard.
      do_reset(); clear_sb();
      for (int i = 0; i < NL; i++) target[i] = 30;
      rand_valid = 1; vpct = 60;
      rand_ready = 1; rpct = 70;
      load_targets(); drive();
      wait_done("rand", 6000);
      for (int i = 0; i < NL; i++) chk($sformatf("rand_cnt%0d", i), out_cnt[i], 30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
